// File: rtl/ups_mode_ctrl_if.sv
// ups_mode_ctrl_if: request/handshake bundle between the mode controller and its environment
//   master : control logic + reset generator side (drives requests, ext_rst_n, err_clr)
//   slave  : ups_mode_ctrl side (drives mode_change, mode_active, busy, timeout_err)
interface ups_mode_ctrl_if #(
  parameter int MODE_W = 2
);
  logic [MODE_W-1:0] mode_req;
  logic              mode_req_vld;
  logic              ext_rst_n;
  logic              err_clr;
  logic              mode_change;
  logic [MODE_W-1:0] mode_active;
  logic              busy;
  logic              timeout_err;
  modport master (
    output mode_req, mode_req_vld, ext_rst_n, err_clr,
    input  mode_change, mode_active, busy, timeout_err
  );
  modport slave (
    input  mode_req, mode_req_vld, ext_rst_n, err_clr,
    output mode_change, mode_active, busy, timeout_err
  );
endinterface

// File: rtl/ups_mode_ctrl.sv
// ups_mode_ctrl: initiator of the UPS mode-change / external-reset handshake
//   clk   : system clock
//   por_n : asynchronous active-low reset
//   bus   : ups_mode_ctrl_if.slave (mode_req, mode_req_vld, ext_rst_n, err_clr in;
//           mode_change, mode_active, busy, timeout_err out, all registered)
//   Optional macro UPS_MODE_CTRL_RETRY_EN: one retry pulse before flagging timeout_err.
module ups_mode_ctrl #(
  parameter int                MODE_W       = 2,
  parameter logic [MODE_W-1:0] RESET_MODE   = '0,
  parameter int                DEBOUNCE_CNT = 16,
  parameter int                RST_TIMEOUT  = 1024
) (
  input  logic           clk,
  input  logic           por_n,
  ups_mode_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int TW = $clog2(RST_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, PULSE, WAIT_LOW, WAIT_HIGH} state_e;

  state_e            state_q, state_d;
  logic [MODE_W-1:0] pend_q, pend_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [MODE_W-1:0] mode_active_q, mode_active_d;
  logic              mode_change_q, mode_change_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              in_wait, tmo, expired, to_set;
`ifdef UPS_MODE_CTRL_RETRY_EN
  logic              retry_q, retry_d;
`endif

  assign in_wait = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
  // >= rather than == so a counter that ran past the limit still expires
  assign tmo     = to_cnt_q >= TW'(RST_TIMEOUT - 1);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    deb_cnt_d     = deb_cnt_q;
    to_cnt_d      = (in_wait && to_cnt_q != TW'(RST_TIMEOUT)) ? to_cnt_q + TW'(1) : to_cnt_q;
    mode_active_d = mode_active_q;
    expired       = 1'b0;
    case (state_q)
      IDLE:
        if (bus.mode_req_vld && bus.mode_req != mode_active_q) begin
          pend_d    = bus.mode_req;
          deb_cnt_d = '0;
          state_d   = DEBOUNCE;
        end
      DEBOUNCE:
        if (!(bus.mode_req_vld && bus.mode_req == pend_q)) state_d = IDLE;
        else if (deb_cnt_q == DW'(DEBOUNCE_CNT - 1)) state_d = PULSE;
        else deb_cnt_d = deb_cnt_q + DW'(1);
      PULSE: begin
        to_cnt_d = '0;
        state_d  = WAIT_LOW;
      end
      WAIT_LOW:
        if (!bus.ext_rst_n) state_d = WAIT_HIGH;
        else expired = tmo;
      WAIT_HIGH:
        // release is checked first so it wins over a same-cycle timeout
        if (bus.ext_rst_n) begin
          mode_active_d = pend_q;
          state_d       = IDLE;
        end else expired = tmo;
      default: state_d = IDLE;
    endcase
`ifdef UPS_MODE_CTRL_RETRY_EN
    retry_d = retry_q;
    to_set  = expired && retry_q;
    if (expired) state_d = retry_q ? IDLE : PULSE;
    if (expired && !retry_q) retry_d = 1'b1;
    if (state_d == IDLE) retry_d = 1'b0;
`else
    to_set = expired;
    if (expired) state_d = IDLE;
`endif
    // a new timeout beats a simultaneous clear
    timeout_err_d = to_set | (timeout_err_q & ~bus.err_clr);
    mode_change_d = state_d == PULSE;
    busy_d        = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      deb_cnt_q     <= '0;
      to_cnt_q      <= '0;
      mode_active_q <= RESET_MODE;
      mode_change_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      deb_cnt_q     <= deb_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mode_active_q <= mode_active_d;
      mode_change_q <= mode_change_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef UPS_MODE_CTRL_RETRY_EN
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) retry_q <= 1'b0;
    else retry_q <= retry_d;
  end
`endif

  assign bus.mode_change = mode_change_q;
  assign bus.mode_active = mode_active_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
endmodule
